// File: rtl/serial_rx.sv
// serial_rx: 3-wire serial link receiver.
// Synchronises clock/data/enable into in_clk and deserialises words.
module serial_rx #(
  parameter int unsigned BITS                = 8,
  parameter logic        LOWBIT_FIRST        = 1'b1,
  parameter logic        SAMPLE_RISING       = 1'b1,
  parameter logic        SERIAL_CLK_INACTIVE = 1'b1,
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned TIMEOUT_CYCLES      = 20000
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_serial_clk,
  input  logic            in_serial,
  input  logic            in_enable,
  output logic [BITS-1:0] out_parallel,
  output logic            out_valid,
  input  logic            in_ack,
  output logic            out_overrun,
  output logic            out_abort,
  output logic            out_busy
);

  localparam int CW = $clog2(BITS) + 1;
  localparam int IW = $clog2(BITS);
  localparam int TW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TLIM =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic [SYNC_STAGES-1:0] en_sync;
  logic                   clk_s;
  logic                   dat_s;
  logic                   en_s;
  logic                   clk_prev;
  logic                   sample_edge;

  state_t                 state;
  state_t                 state_n;
  logic [CW-1:0]          bit_ctr;
  logic [CW-1:0]          bit_ctr_n;
  logic [TW-1:0]          tmo;
  logic [TW-1:0]          tmo_n;
  logic [BITS-1:0]        shreg;
  logic [BITS-1:0]        shreg_n;
  logic [BITS-1:0]        word_c;
  logic [IW-1:0]          idx;
  logic                   last_bit;
  logic                   complete;
  logic                   abort_n;

  logic [BITS-1:0]        hold;
  logic [BITS-1:0]        hold_n;
  logic                   valid_q;
  logic                   valid_n;
  logic                   ovr_q;
  logic                   ovr_n;
  logic                   abort_q;

  // Equal-depth chains keep clock, data and enable aligned.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      clk_sync <= {SYNC_STAGES{SERIAL_CLK_INACTIVE}};
      dat_sync <= {SYNC_STAGES{1'b1}};
      en_sync  <= '0;
      clk_prev <= SERIAL_CLK_INACTIVE;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], in_serial_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], in_serial};
      en_sync  <= {en_sync[SYNC_STAGES-2:0], in_enable};
      clk_prev <= clk_s;
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign en_s  = en_sync[SYNC_STAGES-1];

  assign sample_edge = SAMPLE_RISING ? (clk_s & ~clk_prev)
                                     : (~clk_s & clk_prev);

  assign idx = LOWBIT_FIRST ? bit_ctr[IW-1:0]
                            : IW'(BITS - 1) - bit_ctr[IW-1:0];

  assign last_bit = (bit_ctr == CW'(BITS - 1));

  always_comb begin
    word_c      = shreg;
    word_c[idx] = dat_s;
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state   <= IDLE;
      bit_ctr <= '0;
      tmo     <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      bit_ctr <= bit_ctr_n;
      tmo     <= tmo_n;
      shreg   <= shreg_n;
    end
  end

  // Enable drop has priority over a coincident sample edge.
  always_comb begin
    state_n   = state;
    bit_ctr_n = bit_ctr;
    tmo_n     = tmo;
    shreg_n   = shreg;
    complete  = 1'b0;
    abort_n   = 1'b0;
    unique case (state)
      IDLE: begin
        bit_ctr_n = '0;
        tmo_n     = '0;
        if (en_s) state_n = RECV;
      end
      RECV: begin
        if (!en_s) begin
          state_n   = IDLE;
          bit_ctr_n = '0;
          tmo_n     = '0;
          abort_n   = (bit_ctr != '0);
        end else if (sample_edge) begin
          shreg_n = word_c;
          tmo_n   = '0;
          if (last_bit) begin
            complete  = 1'b1;
            bit_ctr_n = '0;
          end else begin
            bit_ctr_n = bit_ctr + 1'b1;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (bit_ctr != '0)) begin
          if (tmo == TW'(TLIM)) begin
            abort_n   = 1'b1;
            bit_ctr_n = '0;
            tmo_n     = '0;
          end else begin
            tmo_n = tmo + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Ack frees the slot in the same cycle a new word may land in it.
  always_comb begin
    hold_n  = hold;
    valid_n = valid_q;
    ovr_n   = ovr_q;
    if (valid_q && in_ack) begin
      valid_n = 1'b0;
      ovr_n   = 1'b0;
    end
    if (complete) begin
      if (!valid_n) begin
        hold_n  = word_c;
        valid_n = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      hold    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      hold    <= hold_n;
      valid_q <= valid_n;
      ovr_q   <= ovr_n;
      abort_q <= abort_n;
    end
  end

  assign out_parallel = hold;
  assign out_valid    = valid_q;
  assign out_overrun  = ovr_q;
  assign out_abort    = abort_q;
  assign out_busy     = (state == RECV);

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: scoreboard bench for serial_rx.
// LSB-first DUT with 100-cycle timeout, MSB-first DUT with none.
module tb_serial_rx;

  localparam int HALF = 25;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b1;
  logic       sdat = 1'b1;
  logic       en = 1'b0;
  logic       ack = 1'b0;

  logic [7:0] par_l;
  logic [7:0] par_m;
  logic       val_l, val_m;
  logic       ovr_l, ovr_m;
  logic       abt_l, abt_m;
  logic       bsy_l, bsy_m;

  int         errors = 0;
  int         checks = 0;
  int         abt_cnt_l = 0;
  int         abt_cnt_m = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_m[$];

  serial_rx #(
    .TIMEOUT_CYCLES(100)
  ) u_lsb (
    .in_clk       (clk),
    .in_rst       (rst_n),
    .in_serial_clk(sclk),
    .in_serial    (sdat),
    .in_enable    (en),
    .out_parallel (par_l),
    .out_valid    (val_l),
    .in_ack       (ack),
    .out_overrun  (ovr_l),
    .out_abort    (abt_l),
    .out_busy     (bsy_l)
  );

  serial_rx #(
    .LOWBIT_FIRST  (1'b0),
    .TIMEOUT_CYCLES(0)
  ) u_msb (
    .in_clk       (clk),
    .in_rst       (rst_n),
    .in_serial_clk(sclk),
    .in_serial    (sdat),
    .in_enable    (en),
    .out_parallel (par_m),
    .out_valid    (val_m),
    .in_ack       (ack),
    .out_overrun  (ovr_m),
    .out_abort    (abt_m),
    .out_busy     (bsy_m)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (abt_l) abt_cnt_l++;
    if (abt_m) abt_cnt_m++;
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic send_bit(input logic b, input bit last);
    @(negedge clk);
    sclk = 1'b0;
    sdat = b;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    if (!last) repeat (HALF - 1) @(negedge clk);
  endtask

  // Drives nbits of line; full words go to both scoreboards.
  task automatic send_word(input logic [7:0] line, input bit msb,
                           input int nbits);
    for (int i = 0; i < nbits; i++)
      send_bit(msb ? line[7-i] : line[i], i == nbits - 1);
    if (nbits == 8) begin
      exp_q.push_back(msb ? rev8(line) : line);
      exp_m.push_back(msb ? line : rev8(line));
    end
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    while (!val_l && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic frame_start();
    en = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge clk);
    en = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({val_l, ovr_l, abt_l, bsy_l} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags_l: got %b want 0000",
               {val_l, ovr_l, abt_l, bsy_l});
    end
    checks++;
    if ({val_m, ovr_m, abt_m, bsy_m} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags_m: got %b want 0000",
               {val_m, ovr_m, abt_m, bsy_m});
    end
    checks++;
    if (par_l !== 8'h00) begin
      errors++;
      $display("FAIL reset_par: got %h want 00", par_l);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bsy_l !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b want 0", bsy_l);
    end
  endtask

  task automatic test_lsb();
    int n;
    int snap = abt_cnt_l;
    frame_start();
    checks++;
    if (bsy_l !== 1'b1) begin
      errors++;
      $display("FAIL lsb_busy: got %b want 1", bsy_l);
    end
    send_word(8'hA5, 1'b0, 8);
    n = 0;
    while (!val_l && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL lsb_latency: got %0d want 3 clk", n);
    end
    checks++;
    if (par_l !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL lsb_word: got %h want a5", par_l);
    end
    checks++;
    if (par_m !== exp_m.pop_front()) begin
      errors++;
      $display("FAIL lsb_word_m: got %h want a5", par_m);
    end
    do_ack();
    checks++;
    if (val_l !== 1'b0) begin
      errors++;
      $display("FAIL lsb_ack: got %b want 0", val_l);
    end
    frame_end();
    checks++;
    if (abt_cnt_l != snap || ovr_l !== 1'b0) begin
      errors++;
      $display("FAIL lsb_noabort: got %0d/%b want 0/0",
               abt_cnt_l - snap, ovr_l);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] lines[2] = '{8'h3C, 8'h1F};
    logic [7:0] el, em;
    frame_start();
    for (int k = 0; k < 2; k++) begin
      send_word(lines[k], 1'b1, 8);
      wait_valid(50);
      el = exp_q.pop_front();
      em = exp_m.pop_front();
      checks++;
      if (val_l !== 1'b1 || par_l !== el) begin
        errors++;
        $display("FAIL msb_lsbdut%0d: got %b/%h want 1/%h",
                 k, val_l, par_l, el);
      end
      checks++;
      if (val_m !== 1'b1 || par_m !== em) begin
        errors++;
        $display("FAIL msb_msbdut%0d: got %b/%h want 1/%h",
                 k, val_m, par_m, em);
      end
      do_ack();
    end
    frame_end();
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    frame_start();
    fork
      begin
        send_word(8'h12, 1'b0, 8);
        send_word(8'h34, 1'b0, 8);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          wait_valid(900);
          checks++;
          if (val_l !== 1'b1) begin
            errors++;
            $display("FAIL b2b_timeout%0d: got 0 want 1", k);
          end else begin
            e = exp_q.pop_front();
            void'(exp_m.pop_front());
            checks++;
            if (par_l !== e || bsy_l !== 1'b1) begin
              errors++;
              $display("FAIL b2b_word%0d: got %h/%b want %h/1",
                       k, par_l, bsy_l, e);
            end
          end
          do_ack();
        end
      end
    join
    repeat (10) @(negedge clk);
    checks++;
    if (bsy_l !== 1'b1 || val_l !== 1'b0) begin
      errors++;
      $display("FAIL b2b_after: got %b/%b want 1/0", bsy_l, val_l);
    end
    frame_end();
  endtask

  task automatic test_overrun();
    logic [7:0] el, em;
    frame_start();
    send_word(8'h55, 1'b0, 8);
    wait_valid(50);
    send_word(8'hAA, 1'b0, 8);
    repeat (10) @(negedge clk);
    el = exp_q.pop_front();
    em = exp_m.pop_front();
    void'(exp_q.pop_front());
    void'(exp_m.pop_front());
    checks++;
    if (val_l !== 1'b1 || par_l !== el) begin
      errors++;
      $display("FAIL ovr_hold: got %b/%h want 1/%h", val_l, par_l, el);
    end
    checks++;
    if (par_m !== em) begin
      errors++;
      $display("FAIL ovr_hold_m: got %h want %h", par_m, em);
    end
    checks++;
    if (ovr_l !== 1'b1) begin
      errors++;
      $display("FAIL ovr_flag: got %b want 1", ovr_l);
    end
    do_ack();
    checks++;
    if (val_l !== 1'b0 || ovr_l !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: got %b/%b want 0/0", val_l, ovr_l);
    end
    frame_end();
  endtask

  task automatic test_abort_enable();
    int snap = abt_cnt_l;
    logic [7:0] e;
    frame_start();
    send_word(8'h05, 1'b0, 3);
    frame_end();
    checks++;
    if (abt_cnt_l - snap != 1 || val_l !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse: got %0d/%b want 1/0",
               abt_cnt_l - snap, val_l);
    end
    frame_start();
    send_word(8'h81, 1'b0, 8);
    wait_valid(50);
    e = exp_q.pop_front();
    void'(exp_m.pop_front());
    checks++;
    if (val_l !== 1'b1 || par_l !== e) begin
      errors++;
      $display("FAIL abort_next: got %b/%h want 1/%h", val_l, par_l, e);
    end
    do_ack();
    frame_end();
  endtask

  task automatic test_timeout();
    int n = 0;
    int snap_m = abt_cnt_m;
    frame_start();
    send_word(8'h1B, 1'b0, 5);
    while (!abt_l && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 103) begin
      errors++;
      $display("FAIL tmo_cycle: got %0d want 103", n);
    end
    checks++;
    if (val_l !== 1'b0 || bsy_l !== 1'b1) begin
      errors++;
      $display("FAIL tmo_state: got %b/%b want 0/1", val_l, bsy_l);
    end
    checks++;
    if (abt_cnt_m != snap_m) begin
      errors++;
      $display("FAIL tmo_disabled: got %0d want 0", abt_cnt_m - snap_m);
    end
    frame_end();
  endtask

  task automatic test_reset_midword();
    frame_start();
    send_word(8'h5A, 1'b0, 8);
    wait_valid(50);
    send_word(8'h07, 1'b0, 3);
    checks++;
    if (val_l !== 1'b1 || bsy_l !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got %b/%b want 1/1", val_l, bsy_l);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({val_l, ovr_l, abt_l, bsy_l} !== 4'b0000 || par_l !== 8'h00) begin
      errors++;
      $display("FAIL rst_async: got %b/%h want 0000/00",
               {val_l, ovr_l, abt_l, bsy_l}, par_l);
    end
    exp_q.delete();
    exp_m.delete();
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (bsy_l !== 1'b0 || val_l !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: got %b/%b want 0/0", bsy_l, val_l);
    end
  endtask

  initial begin
    test_reset();
    test_lsb();
    test_msb_first();
    test_back_to_back();
    test_overrun();
    test_abort_enable();
    test_timeout();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: got %0d want 0", exp_q.size());
    end
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
